// File: rtl/mic_ifu_pkg.sv
// mic_ifu_pkg: shared types and defaults for the MIC instruction-fetch unit.
package mic_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL,
    S_END
  } ifu_state_t;

  localparam int unsigned IFU_DEFAULT_DEPTH = 4;
  localparam int unsigned IFU_PROG_BYTES    = 34;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mic_ifu_queue.sv
// mic_ifu_queue: DEPTH x 8 prefetch shift queue with push, pop1/pop2 and flush.
// Head is entry 0; pops shift the contents toward the head. An over-pop
// (more bytes requested than held) removes nothing and is reported.
module mic_ifu_queue
  import mic_ifu_pkg::*;
#(
  parameter int unsigned DEPTH = IFU_DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop1,
  input  logic                          pop2,
  input  logic                          flush,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic [cnt_width(DEPTH)-1:0]   count_next,
  output logic [cnt_width(DEPTH)-1:0]   taken,
  output logic [7:0]                    head0,
  output logic [7:0]                    head1,
  output logic                          over_pop
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [7:0]    queue_q [DEPTH];
  logic [7:0]    queue_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] take_req;
  logic [CW-1:0] take_amt;
  logic [CW-1:0] wr_idx;
  logic          over;

  // Pop/shift/append: the new byte lands just behind what survives the pop.
  always_comb begin
    take_req = pop2 ? CW'(2) : (pop1 ? CW'(1) : '0);
    over     = take_req > count_q;
    take_amt = over ? '0 : take_req;
    wr_idx   = count_q - take_amt;
    queue_d  = queue_q;
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        queue_d[i] = '0;
        // Shift selected by comparison so every array index stays constant.
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (j == i + 32'(take_amt)) queue_d[i] = queue_q[j];
        end
        if (push && (i == 32'(wr_idx))) queue_d[i] = push_data;
      end
      count_d = wr_idx + CW'(push);
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_q <= '{default: '0};
      count_q <= '0;
    end else begin
      queue_q <= queue_d;
      count_q <= count_d;
    end
  end

  // Status outputs seen by the fetch controller.
  always_comb begin
    count      = count_q;
    count_next = count_d;
    taken      = flush ? '0 : take_amt;
    head0      = queue_q[0];
    head1      = queue_q[1];
    over_pop   = over && !flush;
  end

endmodule

// File: rtl/mic_fetch_ctrl.sv
// mic_fetch_ctrl: Mic-2 style instruction-fetch unit. Sole master of the
// byte-wide fetch memory; keeps a prefetch queue and presents MBR1/MBR2.
// Optional statistics counters are built when IFU_STATS_EN is defined;
// otherwise fetch_count/stall_count are tied to zero.
module mic_fetch_ctrl
  import mic_ifu_pkg::*;
#(
  parameter int unsigned DEPTH     = IFU_DEFAULT_DEPTH,
  parameter int unsigned MEM_BYTES = IFU_PROG_BYTES
) (
  input  logic        clk_ifu,
  input  logic        reset_ifu_n,
  output logic [31:0] mem_pc,
  output logic        mem_fetch,
  input  logic [7:0]  mem_byte,
  input  logic        take1,
  input  logic        take2,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic [7:0]  mbr1,
  output logic [15:0] mbr2,
  output logic        mbr1_valid,
  output logic        mbr2_valid,
  output logic [31:0] pc_head,
  output logic        eop,
  output logic        take_err,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);

  localparam int unsigned   CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   END_PC  = 32'(MEM_BYTES);

  ifu_state_t    state_q;
  ifu_state_t    state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [31:0]   head_pc_q;
  logic [31:0]   head_pc_d;
  logic          take_err_q;
  logic          take_err_d;
  logic [CW-1:0] q_count;
  logic [CW-1:0] q_count_next;
  logic [CW-1:0] q_taken;
  logic [7:0]    q_head0;
  logic [7:0]    q_head1;
  logic          q_over;

  // A redirect flushes the queue, suppresses this cycle's fetch and masks takes.
  mic_ifu_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk_ifu),
    .rst_n      (reset_ifu_n),
    .push       (mem_fetch),
    .push_data  (mem_byte),
    .pop1       (take1 & ~pc_load),
    .pop2       (take2 & ~pc_load),
    .flush      (pc_load),
    .count      (q_count),
    .count_next (q_count_next),
    .taken      (q_taken),
    .head0      (q_head0),
    .head1      (q_head1),
    .over_pop   (q_over)
  );

  // FSM state register.
  always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
    if (!reset_ifu_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next state: redirect first, then end-of-program, then queue fullness.
  always_comb begin
    state_d = state_q;
    if (pc_load) begin
      state_d = (pc_new >= END_PC) ? S_END : S_RUN;
    end else if (fetch_pc_d >= END_PC) begin
      state_d = S_END;
    end else if (state_q != S_END) begin
      state_d = (q_count_next == DEPTH_C) ? S_FULL : S_RUN;
    end
  end

  // FSM and datapath outputs.
  always_comb begin
    mem_fetch  = (state_q == S_RUN) && (q_count < DEPTH_C) &&
                 (fetch_pc_q < END_PC) && !pc_load;
    mem_pc     = fetch_pc_q;
    mbr1       = q_head0;
    mbr2       = {q_head0, q_head1};
    mbr1_valid = (q_count != '0);
    mbr2_valid = (q_count >= CW'(2));
    pc_head    = head_pc_q;
    eop        = (fetch_pc_q >= END_PC) && (q_count == '0);
    take_err   = take_err_q;
  end

  // PC and error next-values; redirect overrides fetch and consume.
  always_comb begin
    fetch_pc_d = pc_load ? pc_new : fetch_pc_q + 32'(mem_fetch);
    head_pc_d  = pc_load ? pc_new : head_pc_q + 32'(q_taken);
    take_err_d = take_err_q | q_over;
  end

  // PC registers and sticky over-take flag.
  always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
    if (!reset_ifu_n) begin
      fetch_pc_q <= '0;
      head_pc_q  <= '0;
      take_err_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      take_err_q <= take_err_d;
    end
  end

`ifdef IFU_STATS_EN
  logic [15:0] fetch_count_q;
  logic [15:0] fetch_count_d;
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  // Saturating fetch and full-stall event counters.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (mem_fetch && (fetch_count_q != '1))         fetch_count_d = fetch_count_q + 16'd1;
    if ((state_q == S_FULL) && (stall_count_q != '1)) stall_count_d = stall_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
    if (!reset_ifu_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mic_fetch_ctrl.sv
// tb_mic_fetch_ctrl: directed self-checking bench for mic_fetch_ctrl.
// Program image: mem[a] = 8'hC0 + a for a < 34.
module tb_mic_fetch_ctrl;
  import mic_ifu_pkg::*;

  localparam int unsigned PROG = 34;

  logic        clk_ifu = 1'b0;
  logic        reset_ifu_n = 1'b0;
  logic [31:0] mem_pc;
  logic        mem_fetch;
  logic [7:0]  mem_byte = 8'h00;
  logic        take1 = 1'b0;
  logic        take2 = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_new = '0;
  logic [7:0]  mbr1;
  logic [15:0] mbr2;
  logic        mbr1_valid;
  logic        mbr2_valid;
  logic [31:0] pc_head;
  logic        eop;
  logic        take_err;
  logic [15:0] fetch_count;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;
  logic mem_oob = 1'b0;

  mic_fetch_ctrl #(.DEPTH(4), .MEM_BYTES(34)) dut (
    .clk_ifu     (clk_ifu),
    .reset_ifu_n (reset_ifu_n),
    .mem_pc      (mem_pc),
    .mem_fetch   (mem_fetch),
    .mem_byte    (mem_byte),
    .take1       (take1),
    .take2       (take2),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .mbr1        (mbr1),
    .mbr2        (mbr2),
    .mbr1_valid  (mbr1_valid),
    .mbr2_valid  (mbr2_valid),
    .pc_head     (pc_head),
    .eop         (eop),
    .take_err    (take_err),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk_ifu = ~clk_ifu;

  // Fetch memory: samples the request on the falling edge, 1-cycle latency.
  always @(negedge clk_ifu) begin
    if (mem_fetch) begin
      if (mem_pc < PROG) mem_byte <= 8'hC0 + mem_pc[7:0];
      else begin
        mem_byte <= 8'hEE;
        mem_oob  <= 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_ifu);
    #1;
  endtask

  task automatic clear_inputs();
    take1 = 1'b0; take2 = 1'b0; pc_load = 1'b0; pc_new = '0;
  endtask

  // Holds reset for two cycles, releases it just after a rising edge (cycle 0).
  task automatic reset_release();
    clear_inputs();
    reset_ifu_n = 1'b0;
    step(); step();
    reset_ifu_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_ifu_n = 1'b0;
    step(); step();
    checks++; if (mem_pc !== 32'd0) begin failures++; $display("FAIL rst_mem_pc got=%h exp=%h", mem_pc, 32'd0); end
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL rst_mem_fetch got=%b exp=0", mem_fetch); end
    checks++; if (mbr1 !== 8'h00) begin failures++; $display("FAIL rst_mbr1 got=%h exp=00", mbr1); end
    checks++; if (mbr2 !== 16'h0000) begin failures++; $display("FAIL rst_mbr2 got=%h exp=0000", mbr2); end
    checks++; if ({mbr1_valid, mbr2_valid} !== 2'b00) begin failures++; $display("FAIL rst_valids got=%b exp=00", {mbr1_valid, mbr2_valid}); end
    checks++; if (pc_head !== 32'd0) begin failures++; $display("FAIL rst_pc_head got=%h exp=0", pc_head); end
    checks++; if ({eop, take_err} !== 2'b00) begin failures++; $display("FAIL rst_eop_err got=%b exp=00", {eop, take_err}); end
    checks++; if ({fetch_count, stall_count} !== 32'd0) begin failures++; $display("FAIL rst_stats got=%h/%h exp=0/0", fetch_count, stall_count); end
    checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_fill();
    reset_ifu_n = 1'b1;
    #1;
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL fill_c0_fetch got=%b exp=0", mem_fetch); end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (mem_fetch !== 1'b1 || mem_pc !== 32'(c - 1)) begin failures++; $display("FAIL fill_fetch c=%0d got=%b/%0d exp=1/%0d", c, mem_fetch, mem_pc, c - 1); end
      if (c == 1) begin
        checks++; if (mbr1_valid !== 1'b0) begin failures++; $display("FAIL fill_c1_v1 got=%b exp=0", mbr1_valid); end
      end
      if (c == 2) begin
        checks++; if (mbr1_valid !== 1'b1 || mbr1 !== 8'hC0 || mbr2_valid !== 1'b0) begin failures++; $display("FAIL fill_c2 got=%b/%h/%b exp=1/c0/0", mbr1_valid, mbr1, mbr2_valid); end
      end
      if (c == 3) begin
        checks++; if (mbr2_valid !== 1'b1 || mbr2 !== 16'hC0C1) begin failures++; $display("FAIL fill_c3 got=%b/%h exp=1/c0c1", mbr2_valid, mbr2); end
      end
    end
    step();
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL fill_full_fetch got=%b exp=0", mem_fetch); end
    checks++; if (dut.state_q !== S_FULL) begin failures++; $display("FAIL fill_state got=%0d exp=%0d", dut.state_q, S_FULL); end
    checks++; if (dut.q_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", dut.q_count); end
    checks++; if (mbr2 !== 16'hC0C1 || pc_head !== 32'd0) begin failures++; $display("FAIL fill_head got=%h/%0d exp=c0c1/0", mbr2, pc_head); end
`ifdef IFU_STATS_EN
    checks++; if (fetch_count !== 16'd4 || stall_count !== 16'd0) begin failures++; $display("FAIL fill_stats got=%0d/%0d exp=4/0", fetch_count, stall_count); end
`else
    checks++; if (fetch_count !== 16'd0 || stall_count !== 16'd0) begin failures++; $display("FAIL fill_stats got=%0d/%0d exp=0/0", fetch_count, stall_count); end
`endif
  endtask

  // Starts in the FULL cycle left by test_fill.
  task automatic test_take2();
    take2 = 1'b1;
    step();
    checks++; if (mbr2 !== 16'hC2C3 || pc_head !== 32'd2) begin failures++; $display("FAIL t2_c6 got=%h/%0d exp=c2c3/2", mbr2, pc_head); end
    checks++; if (mem_fetch !== 1'b1 || mem_pc !== 32'd4 || dut.state_q !== S_RUN) begin failures++; $display("FAIL t2_c6_fetch got=%b/%0d/%0d exp=1/4/%0d", mem_fetch, mem_pc, dut.state_q, S_RUN); end
    step();
    checks++; if (mbr1 !== 8'hC4 || mbr1_valid !== 1'b1 || mbr2_valid !== 1'b0) begin failures++; $display("FAIL t2_c7 got=%h/%b/%b exp=c4/1/0", mbr1, mbr1_valid, mbr2_valid); end
    checks++; if (pc_head !== 32'd4 || take_err !== 1'b0) begin failures++; $display("FAIL t2_c7_pc got=%0d/%b exp=4/0", pc_head, take_err); end
    step();
    take2 = 1'b0;
    checks++; if (mbr2 !== 16'hC4C5 || pc_head !== 32'd4) begin failures++; $display("FAIL t2_c8 got=%h/%0d exp=c4c5/4", mbr2, pc_head); end
    checks++; if (take_err !== 1'b1) begin failures++; $display("FAIL t2_err got=%b exp=1", take_err); end
`ifdef IFU_STATS_EN
    checks++; if (fetch_count !== 16'd6 || stall_count !== 16'd1) begin failures++; $display("FAIL t2_stats got=%0d/%0d exp=6/1", fetch_count, stall_count); end
`endif
  endtask

  task automatic test_pc_load();
    reset_release();
    step(); step(); step();
    pc_load = 1'b1; pc_new = 32'd10; take1 = 1'b1;
    #1;
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL ld_n_fetch got=%b exp=0", mem_fetch); end
    step();
    clear_inputs();
    #1;
    checks++; if (mem_fetch !== 1'b1 || mem_pc !== 32'd10) begin failures++; $display("FAIL ld_n1_fetch got=%b/%0d exp=1/10", mem_fetch, mem_pc); end
    checks++; if (mbr1_valid !== 1'b0 || pc_head !== 32'd10) begin failures++; $display("FAIL ld_n1_q got=%b/%0d exp=0/10", mbr1_valid, pc_head); end
    step();
    checks++; if (mbr1 !== 8'hCA || mbr1_valid !== 1'b1 || pc_head !== 32'd10) begin failures++; $display("FAIL ld_n2 got=%h/%b/%0d exp=ca/1/10", mbr1, mbr1_valid, pc_head); end
    checks++; if (take_err !== 1'b0 || mem_pc !== 32'd11) begin failures++; $display("FAIL ld_n2_misc got=%b/%0d exp=0/11", take_err, mem_pc); end
  endtask

  task automatic test_pc_load_end();
    pc_load = 1'b1; pc_new = 32'd40;
    #1;
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL end_m_fetch got=%b exp=0", mem_fetch); end
    step();
    clear_inputs();
    #1;
    checks++; if (dut.state_q !== S_END || eop !== 1'b1) begin failures++; $display("FAIL end_m1 got=%0d/%b exp=%0d/1", dut.state_q, eop, S_END); end
    checks++; if (mem_fetch !== 1'b0 || mbr1_valid !== 1'b0 || pc_head !== 32'd40) begin failures++; $display("FAIL end_m1_q got=%b/%b/%0d exp=0/0/40", mem_fetch, mbr1_valid, pc_head); end
    step();
    checks++; if (mem_fetch !== 1'b0 || eop !== 1'b1) begin failures++; $display("FAIL end_m2 got=%b/%b exp=0/1", mem_fetch, eop); end
  endtask

  task automatic test_run_to_end();
    pc_load = 1'b1; pc_new = 32'd30;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) clear_inputs();
      #1;
      checks++; if (mem_fetch !== 1'b1 || mem_pc !== 32'(30 + k)) begin failures++; $display("FAIL rte_fetch k=%0d got=%b/%0d exp=1/%0d", k, mem_fetch, mem_pc, 30 + k); end
    end
    step();
    checks++; if (mem_fetch !== 1'b0 || dut.state_q !== S_END || eop !== 1'b0) begin failures++; $display("FAIL rte_end got=%b/%0d/%b exp=0/%0d/0", mem_fetch, dut.state_q, eop, S_END); end
    checks++; if (mbr2 !== 16'hDEDF || pc_head !== 32'd30) begin failures++; $display("FAIL rte_head got=%h/%0d exp=dedf/30", mbr2, pc_head); end
    take1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      logic [7:0] exp_b;
      exp_b = 8'hDE + 8'(k);
      step();
      checks++; if (mbr1 !== exp_b || pc_head !== 32'(30 + k) || eop !== 1'b0) begin failures++; $display("FAIL rte_drain k=%0d got=%h/%0d/%b exp=%h/%0d/0", k, mbr1, pc_head, eop, exp_b, 30 + k); end
    end
    step();
    take1 = 1'b0;
    checks++; if (eop !== 1'b1 || mbr1_valid !== 1'b0 || pc_head !== 32'd34) begin failures++; $display("FAIL rte_eop got=%b/%b/%0d exp=1/0/34", eop, mbr1_valid, pc_head); end
    checks++; if (take_err !== 1'b0) begin failures++; $display("FAIL rte_err got=%b exp=0", take_err); end
    checks++; if (mem_oob !== 1'b0) begin failures++; $display("FAIL rte_oob got=%b exp=0", mem_oob); end
  endtask

  task automatic test_async_reset();
    reset_release();
    step(); step(); step();
    checks++; if (mem_fetch !== 1'b1 || mbr1 !== 8'hC0) begin failures++; $display("FAIL ar_pre got=%b/%h exp=1/c0", mem_fetch, mbr1); end
`ifdef IFU_STATS_EN
    checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL ar_pre_stats got=%0d exp=2", fetch_count); end
`endif
    #2;
    reset_ifu_n = 1'b0;
    #1;
    checks++; if (mem_fetch !== 1'b0 || mem_pc !== 32'd0 || mbr1 !== 8'h00 || mbr2 !== 16'h0000) begin failures++; $display("FAIL ar_zero got=%b/%0d/%h/%h exp=0/0/00/0000", mem_fetch, mem_pc, mbr1, mbr2); end
    checks++; if (mbr1_valid !== 1'b0 || fetch_count !== 16'd0 || dut.state_q !== S_IDLE) begin failures++; $display("FAIL ar_state got=%b/%0d/%0d exp=0/0/%0d", mbr1_valid, fetch_count, dut.state_q, S_IDLE); end
    step();
    reset_ifu_n = 1'b1;
    #1;
    checks++; if (mem_fetch !== 1'b0) begin failures++; $display("FAIL ar_c0 got=%b exp=0", mem_fetch); end
    step();
    checks++; if (mem_fetch !== 1'b1 || mem_pc !== 32'd0) begin failures++; $display("FAIL ar_c1 got=%b/%0d exp=1/0", mem_fetch, mem_pc); end
    step();
    checks++; if (mbr1 !== 8'hC0 || mbr1_valid !== 1'b1) begin failures++; $display("FAIL ar_c2 got=%h/%b exp=c0/1", mbr1, mbr1_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_take2();
    test_pc_load();
    test_pc_load_end();
    test_run_to_end();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
